// File: rtl/accel_mul_unit_pkg.sv
// Shared constants for the custom-opcode multiplier: opcode value and FSM state encodings.
package accel_mul_unit_pkg;

  localparam logic [6:0] RVOP_ACCEL = 7'b1111111;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_CALC = 2'd1,
    ACC_DONE = 2'd2
  } acc_state_e;

endpackage

// File: rtl/accel_mul_unit_if.sv
// Decode-to-multiplier bundle: operands and start in, stall/valid/product out.
interface accel_mul_unit_if #(
  parameter int WIDTH = 8
);

  logic                 start_i;
  logic [WIDTH-1:0]     A_i;
  logic [WIDTH-1:0]     B_i;
  logic                 busy_o;
  logic                 valid_o;
  logic [2*WIDTH-1:0]   result_o;

  modport master (
    output start_i, A_i, B_i,
    input  busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, A_i, B_i,
    output busy_o, valid_o, result_o
  );

endinterface

// File: rtl/accel_mul_datapath.sv
// Shift-add datapath: multiplicand, multiplier shift register and accumulator.
// prod_nxt_o is the accumulator value after the current step, so the last step can be latched directly.
module accel_mul_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   prod_nxt_o
);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;

  assign prod_nxt_o = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (step_i) begin
      acc_q    <= prod_nxt_o;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/accel_mul_unit.sv
// Fixed-latency 8-iteration unsigned multiplier; stalls decode via busy_o while computing,
// then pulses valid_o for the single DONE cycle and holds result_o until the next product.
module accel_mul_unit
  import accel_mul_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  accel_mul_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  acc_state_e           state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 valid_q;
  logic [2*WIDTH-1:0]   result_q;
  logic [2*WIDTH-1:0]   prod_nxt;
  logic                 load;
  logic                 step;

  assign load = (state_q == ACC_IDLE) && bus.start_i;
  assign step = (state_q == ACC_CALC);

  accel_mul_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .step_i     (step),
    .a_i        (bus.A_i),
    .b_i        (bus.B_i),
    .prod_nxt_o (prod_nxt)
  );

  // Result and valid are latched on the final CALC step so both are visible during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACC_IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ACC_IDLE: begin
          if (bus.start_i) begin
            state_q <= ACC_CALC;
            cnt_q   <= '0;
          end
        end
        ACC_CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q  <= ACC_DONE;
            valid_q  <= 1'b1;
            result_q <= prod_nxt;
          end
        end
        ACC_DONE: state_q <= ACC_IDLE;
        default:  state_q <= ACC_IDLE;
      endcase
    end
  end

  assign bus.busy_o   = load | step;
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;

endmodule
